// File: rtl/fft_pkg.sv
// Shared types and helpers for the iterative radix-2 DIT FFT controller.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_e;

  // Fields are sized for the largest supported transform (N_LOG2 = 12);
  // users keep only the low bits they need.
  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] tw;
  } fft_addr_t;

  // Ceiling log2, usable in constant expressions. fft_clog2(1) = 0.
  function automatic int unsigned fft_clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Operand and twiddle addresses of butterfly k in stage s.
  // A and B sit 2^s apart inside groups of 2^(s+1); the twiddle index
  // is the position within the group scaled to the full-size circle.
  function automatic fft_addr_t fft_addr(input logic [11:0] k,
                                         input int unsigned s,
                                         input int unsigned n_log2);
    fft_addr_t   r;
    logic [11:0] lo;
    lo   = k & ((12'd1 << s) - 12'd1);
    r.a  = ((k >> s) << (s + 1)) | lo;
    r.b  = r.a + (12'd1 << s);
    r.tw = lo << (n_log2 - 1 - s);
    return r;
  endfunction

endpackage

// File: rtl/fft_iter_butterfly_ctrl_if.sv
// Controller-side bus: start/status, operand fetch, butterfly strobes
// and write-back. The controller uses the slave view.
interface fft_iter_butterfly_ctrl_if
  import fft_pkg::*;
#(
  parameter int N_LOG2 = 10
) ();
  localparam int SW = fft_clog2(N_LOG2);

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [N_LOG2-1:0] rd_addr_a;
  logic [N_LOG2-1:0] rd_addr_b;
  logic [N_LOG2-2:0] tw_addr;
  logic              but_strb;
  logic              but_strb_out;
  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr_a;
  logic [N_LOG2-1:0] wr_addr_b;
  logic [SW-1:0]     stage;
  logic              err;

  modport slave (
    input  start, but_strb_out,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, but_strb,
           wr_en, wr_addr_a, wr_addr_b, stage, err
  );

  modport master (
    output start, but_strb_out,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, but_strb,
           wr_en, wr_addr_a, wr_addr_b, stage, err
  );
endinterface

// File: rtl/fft_addr_fifo.sv
// Write-back address queue. Head is visible combinationally so the
// write can use it in the same cycle as the butterfly result strobe.
module fft_addr_fifo
  import fft_pkg::*;
#(
  parameter int DW    = 20,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic          one_left,
  output logic          ovf,
  output logic          udf
);
  localparam int AW = fft_clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign empty    = (wp_q == rp_q);
  assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign one_left = ((wp_q - rp_q) == (AW+1)'(1));
  assign head     = mem_q[rp_q[AW-1:0]];

  // A pop frees a slot in the same cycle, so push-while-full is fine
  // when it coincides with a valid pop. A pop on empty is dropped.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign ovf     = push && !push_ok;
  assign udf     = pop && empty;

  // Next pointer values.
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (push_ok) wp_d = wp_q + (AW+1)'(1);
    if (pop_ok)  rp_d = rp_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage; contents are only observed through non-empty slots.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fft_iter_butterfly_ctrl.sv
// Operand-fetch / write-back sequencer for the in-place iterative
// radix-2 DIT FFT. Issues one butterfly every BUT_CLK_CYCLE cycles and
// drains between stages so reads never overtake earlier writes.
module fft_iter_butterfly_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2        = 10,
  parameter int BUT_CLK_CYCLE = 5,
  parameter int MEM_RD_LAT    = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input logic                     clk,
  input logic                     rst,
  fft_iter_butterfly_ctrl_if.slave bus
);
  localparam int SW = fft_clog2(N_LOG2);
  localparam int IW = fft_clog2(BUT_CLK_CYCLE) + 1;
  localparam int DW = 2 * N_LOG2;

  localparam logic [N_LOG2-1:0] K_LAST     = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [SW-1:0]     S_LAST     = SW'(N_LOG2 - 1);
  localparam logic [IW-1:0]     IVL_RELOAD = IW'(BUT_CLK_CYCLE - 1);

  fft_state_e            state_q, state_d;
  logic [SW-1:0]         s_q, s_d;
  logic [N_LOG2-1:0]     k_q, k_d;
  logic [IW-1:0]         ivl_q, ivl_d;
  logic [MEM_RD_LAT-1:0] dly_q, dly_d;
  logic                  err_q;

  logic                  fire;
  logic                  busy, done;
  logic                  drained;
  fft_addr_t             addr;
  logic [DW-1:0]         fifo_head;
  logic                  fifo_full, fifo_empty, fifo_one, fifo_ovf, fifo_udf;
  logic [36:0]           unused_bits;

  assign fire = (state_q == ST_ISSUE) && (ivl_q == '0);
  assign addr = fft_addr(12'(k_q), 32'(s_q), N_LOG2);

  // The stage is complete once no read is still in the memory pipe and
  // the queue is empty, or its last entry is being written back now.
  assign drained = (dly_q == '0) &&
                   (fifo_empty || (fifo_one && bus.but_strb_out));

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      ivl_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      ivl_q   <= ivl_d;
    end
  end

  // Next-state, counter updates and status outputs.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    ivl_d   = ivl_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s_d   = '0;
        k_d   = '0;
        ivl_d = '0;
        if (bus.start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy = 1'b1;
        if (fire) begin
          ivl_d = IVL_RELOAD;
          k_d   = k_q + N_LOG2'(1);
          if (k_q == K_LAST) state_d = ST_DRAIN;
        end else begin
          ivl_d = ivl_q - IW'(1);
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drained) begin
          if (s_q != S_LAST) begin
            s_d     = s_q + SW'(1);
            k_d     = '0;
            ivl_d   = '0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-strobe delay line matching the memory read latency.
  assign dly_d[0] = fire;
  genvar gi;
  for (gi = 1; gi < MEM_RD_LAT; gi++) begin : g_dly
    assign dly_d[gi] = dly_q[gi-1];
  end

  // Delay-line register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dly_q <= '0;
    else      dly_q <= dly_d;
  end

  // Sticky error on queue overflow or underflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      err_q <= 1'b0;
    else if (fifo_ovf || fifo_udf) err_q <= 1'b1;
  end

  fft_addr_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fire),
    .din      ({addr.a[N_LOG2-1:0], addr.b[N_LOG2-1:0]}),
    .pop      (bus.but_strb_out),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one),
    .ovf      (fifo_ovf),
    .udf      (fifo_udf)
  );

  // Upper struct bits and the full flag are not needed here.
  assign unused_bits = {addr, fifo_full};

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.rd_en     = fire;
  assign bus.rd_addr_a = fire ? addr.a[N_LOG2-1:0]  : '0;
  assign bus.rd_addr_b = fire ? addr.b[N_LOG2-1:0]  : '0;
  assign bus.tw_addr   = fire ? addr.tw[N_LOG2-2:0] : '0;
  assign bus.but_strb  = dly_q[MEM_RD_LAT-1];
  // Write strobe follows the butterfly directly but is held low in reset;
  // addresses read as zero when there is no queued pair.
  assign bus.wr_en     = bus.but_strb_out & rst;
  assign bus.wr_addr_a = fifo_empty ? '0 : fifo_head[DW-1:N_LOG2];
  assign bus.wr_addr_b = fifo_empty ? '0 : fifo_head[N_LOG2-1:0];
  assign bus.stage     = s_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_fft_iter_butterfly_ctrl.sv
// Scoreboard bench for the FFT butterfly controller, N = 8.
module tb_fft_iter_butterfly_ctrl;
  import fft_pkg::*;

  localparam int NL  = 3;
  localparam int BCC = 5;
  localparam int LAT = 1;
  localparam int BFL = 5;

  typedef struct {
    int s;
    int k;
    int a;
    int b;
    int tw;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Hand-computed read order for N = 8, index = s*4 + k.
  int tbl_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int tbl_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int tbl_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  exp_t rd_q[$];
  exp_t wr_q[$];
  int   due_q[$];

  int   start_cyc = 0;
  bit   first_pending = 0;
  int   last_rd_cyc = 0;
  int   last_wr_cyc = 0;
  int   st0_last_wr = -1;
  bit   st1_seen = 0;
  int   done_cnt = 0;
  bit   prev_rd = 0;
  bit   spur_req = 0;
  bit   expect_spur = 0;
  int   extra_idx = -1;
  int   strobe_n = 0;

  fft_iter_butterfly_ctrl_if #(.N_LOG2(NL)) bus ();

  fft_iter_butterfly_ctrl #(
    .N_LOG2        (NL),
    .BUT_CLK_CYCLE (BCC),
    .MEM_RD_LAT    (LAT),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  wire [21:0] outs_all = {bus.busy, bus.done, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
                          bus.tw_addr, bus.but_strb, bus.wr_en, bus.wr_addr_a,
                          bus.wr_addr_b, bus.stage, bus.err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_expect();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      e.s  = i / 4;
      e.k  = i % 4;
      e.a  = tbl_a[i];
      e.b  = tbl_b[i];
      e.tw = tbl_tw[i];
      rd_q.push_back(e);
      wr_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input bit expect_run);
    @(negedge clk);
    if (expect_run) begin
      push_expect();
      start_cyc     = cyc;
      first_pending = 1'b1;
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    check("done_reached", done_cnt, target);
  endtask

  // Butterfly model: result strobe BFL cycles after each input strobe,
  // one chosen strobe held back 20 extra cycles; flushed by reset.
  initial begin : bfly_model
    bus.but_strb_out = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        due_q.delete();
        bus.but_strb_out = 1'b0;
      end else begin
        bus.but_strb_out = (due_q.size() > 0) && (due_q[0] == cyc);
        if (bus.but_strb_out) void'(due_q.pop_front());
        if (spur_req) bus.but_strb_out = 1'b1;
        if (bus.but_strb) begin
          due_q.push_back(cyc + BFL + ((strobe_n == extra_idx) ? 20 : 0));
          strobe_n++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a read,
  // a write-back or a done pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        prev_rd = 1'b0;
      end else begin
        if (bus.rd_en) begin
          $display("rd  cyc=%0d stage=%0d a=%0d b=%0d tw=%0d", cyc, bus.stage,
                   bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
          if (rd_q.size() == 0) begin
            check("rd_unexpected", 1, 0);
          end else begin
            e = rd_q.pop_front();
            check("rd_stage", bus.stage, e.s);
            check("rd_addr_a", bus.rd_addr_a, e.a);
            check("rd_addr_b", bus.rd_addr_b, e.b);
            check("tw_addr", bus.tw_addr, e.tw);
            if (first_pending) begin
              check("start_latency", cyc, start_cyc + 1);
              first_pending = 1'b0;
            end
            if (e.k != 0) check("issue_interval", cyc - last_rd_cyc, BCC);
            if (e.s == 1 && e.k == 0) begin
              check("stage_after_write", cyc > st0_last_wr, 1);
              st1_seen = 1'b1;
            end
            last_rd_cyc = cyc;
          end
        end
        if (bus.but_strb || prev_rd) check("strb_align", bus.but_strb, prev_rd);
        prev_rd = bus.rd_en;
        if (bus.wr_en && !expect_spur) begin
          $display("wr  cyc=%0d a=%0d b=%0d", cyc, bus.wr_addr_a, bus.wr_addr_b);
          if (wr_q.size() == 0) begin
            check("wr_unexpected", 1, 0);
          end else begin
            e = wr_q.pop_front();
            check("wr_addr_a", bus.wr_addr_a, e.a);
            check("wr_addr_b", bus.wr_addr_b, e.b);
            last_wr_cyc = cyc;
            if (e.s == 0 && e.k == 3) st0_last_wr = cyc;
          end
        end
        if (bus.done) begin
          $display("done cyc=%0d", cyc);
          done_cnt++;
          check("done_busy", bus.busy, 0);
          check("done_latency", cyc, last_wr_cyc + 1);
        end
      end
    end
  end

  initial begin : stimulus
    fft_addr_t fa;
    bus.start = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Package address function against the hand table.
    for (int i = 0; i < 12; i++) begin
      fa = fft_addr(12'(i % 4), i / 4, NL);
      check("pkg_addr", {20'd0, fa}, {20'd0, 12'(tbl_a[i]), 12'(tbl_b[i]), 12'(tbl_tw[i])});
    end

    repeat (3) @(negedge clk);
    #1 check("reset_outputs", outs_all, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("idle_busy", bus.busy, 0);

    // Transform 1: delayed final stage-0 result, ignored second start.
    extra_idx = 3;
    pulse_start(1'b1);
    repeat (8) @(negedge clk);
    pulse_start(1'b0);
    wait_done(1, 400);
    extra_idx = -1;
    repeat (10) @(negedge clk);
    #1;
    check("single_done", done_cnt, 1);
    check("t1_err", bus.err, 0);
    check("t1_rd_left", rd_q.size(), 0);
    check("t1_wr_left", wr_q.size(), 0);

    // Transform 2: reset in the middle of stage 1.
    st1_seen = 1'b0;
    pulse_start(1'b1);
    for (int i = 0; i < 300 && !st1_seen; i++) @(negedge clk);
    check("stage1_reached", st1_seen, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("midrun_reset_outputs", outs_all, 0);
    rd_q.delete();
    wr_q.delete();
    first_pending = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_reset_err", bus.err, 0);
    check("post_reset_stage", bus.stage, 0);

    // Spurious result strobe while idle.
    repeat (2) @(negedge clk);
    @(posedge clk);
    expect_spur = 1'b1;
    spur_req    = 1'b1;
    @(negedge clk);
    #1 check("spur_wr_en", bus.wr_en, 1);
    @(posedge clk);
    spur_req = 1'b0;
    @(posedge clk);
    expect_spur = 1'b0;
    @(negedge clk);
    #1 check("spur_err", bus.err, 1);

    // Transform 3: full sequence from stage 0 after the underflow.
    pulse_start(1'b1);
    wait_done(2, 400);
    repeat (5) @(negedge clk);
    #1;
    check("t3_err_sticky", bus.err, 1);
    check("t3_rd_left", rd_q.size(), 0);
    check("t3_wr_left", wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
